npusch_demap_ctrl: RTL and testbench



---
 rtl/npusch_demap_ctrl_if.sv | 38 +++
 rtl/npusch_demap_ctrl.sv | 148 ++++++++++++++
 tb/tb_npusch_demap_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/npusch_demap_ctrl_if.sv
// +----------------------------------------------------------------------------+
// | Module      : npusch_demap_ctrl_if                                         |
// | Description : Allocation, FFT-strobe and demapper-control bundle for the   |
// |               NPUSCH demapper sequencer.                                   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

interface npusch_demap_ctrl_if;
    logic       i_start;
    logic       i_abort;
    logic [5:0] i_Isc;
    logic [2:0] i_N_RU;
    logic       i_FFT_Valid;
    logic       o_en;
    logic [5:0] o_Isc;
    logic       o_DMRS_valid;
    logic       o_data_valid;
    logic [2:0] o_sym_idx;
    logic [7:0] o_slot_idx;
    logic       o_busy;
    logic       o_done;
    logic       o_isc_err;

    modport master (
        output i_start, i_abort, i_Isc, i_N_RU, i_FFT_Valid,
        input  o_en, o_Isc, o_DMRS_valid, o_data_valid, o_sym_idx,
               o_slot_idx, o_busy, o_done, o_isc_err
    );

    modport slave (
        input  i_start, i_abort, i_Isc, i_N_RU, i_FFT_Valid,
        output o_en, o_Isc, o_DMRS_valid, o_data_valid, o_sym_idx,
               o_slot_idx, o_busy, o_done, o_isc_err
    );
endinterface

`default_nettype wire

// File: rtl/npusch_demap_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module      : npusch_demap_ctrl                                            |
// | Description : Walks one NPUSCH allocation symbol by symbol on the FFT      |
// |               strobe and drives the resource-element demapper.             |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module npusch_demap_ctrl #(
    parameter int SYMS_PER_SLOT = 7,
    parameter int DMRS_SYM      = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    npusch_demap_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] isc_q, isc_d;
    logic [2:0] sym_idx_q, sym_idx_d;
    logic [7:0] slot_idx_q, slot_idx_d;
    logic [7:0] last_slot_q, last_slot_d;
    logic       isc_err_q, isc_err_d;

    logic       w_isc_legal;
    logic [4:0] w_slots_per_ru;
    logic [3:0] w_num_ru;
    logic [8:0] w_total;
    logic [8:0] w_total_m1;
    logic       w_last_sym;
    logic       w_is_dmrs;

    assign w_isc_legal = (bus.i_Isc < 6'd19);

    always_comb begin
        w_slots_per_ru = 5'd2;
        if (bus.i_Isc <= 6'd11)      w_slots_per_ru = 5'd16;
        else if (bus.i_Isc <= 6'd15) w_slots_per_ru = 5'd8;
        else if (bus.i_Isc <= 6'd17) w_slots_per_ru = 5'd4;
    end

    always_comb begin
        w_num_ru = {1'b0, bus.i_N_RU} + 4'd1;
        case (bus.i_N_RU)
            3'd6:    w_num_ru = 4'd8;
            3'd7:    w_num_ru = 4'd10;
            default: w_num_ru = {1'b0, bus.i_N_RU} + 4'd1;
        endcase
    end

    // Largest legal product is 10 x 16 = 160, so the 8-bit slot counter never overflows.
    assign w_total    = {5'd0, w_num_ru} * {4'd0, w_slots_per_ru};
    assign w_total_m1 = w_total - 9'd1;

    assign w_last_sym = (sym_idx_q == 3'(SYMS_PER_SLOT - 1));
    assign w_is_dmrs  = (sym_idx_q == 3'(DMRS_SYM));

    always_comb begin
        state_d     = state_q;
        isc_d       = isc_q;
        sym_idx_d   = sym_idx_q;
        slot_idx_d  = slot_idx_q;
        last_slot_d = last_slot_q;
        isc_err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!bus.i_abort && bus.i_start) begin
                    if (w_isc_legal) begin
                        state_d     = S_RUN;
                        isc_d       = bus.i_Isc;
                        sym_idx_d   = 3'd0;
                        slot_idx_d  = 8'd0;
                        last_slot_d = w_total_m1[7:0];
                    end else begin
                        isc_err_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (bus.i_abort) begin
                    state_d    = S_IDLE;
                    sym_idx_d  = 3'd0;
                    slot_idx_d = 8'd0;
                end else if (bus.i_FFT_Valid) begin
                    if (w_last_sym) begin
                        sym_idx_d = 3'd0;
                        if (slot_idx_q == last_slot_q) begin
                            state_d    = S_DONE;
                            slot_idx_d = 8'd0;
                        end else begin
                            slot_idx_d = slot_idx_q + 8'd1;
                        end
                    end else begin
                        sym_idx_d = sym_idx_q + 3'd1;
                    end
                end
            end
            S_DONE: begin
                state_d    = S_IDLE;
                sym_idx_d  = 3'd0;
                slot_idx_d = 8'd0;
            end
            default: begin
                state_d    = S_IDLE;
                sym_idx_d  = 3'd0;
                slot_idx_d = 8'd0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            isc_q       <= 6'd0;
            sym_idx_q   <= 3'd0;
            slot_idx_q  <= 8'd0;
            last_slot_q <= 8'd0;
            isc_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            isc_q       <= isc_d;
            sym_idx_q   <= sym_idx_d;
            slot_idx_q  <= slot_idx_d;
            last_slot_q <= last_slot_d;
            isc_err_q   <= isc_err_d;
        end
    end

    assign bus.o_en         = (state_q == S_RUN);
    assign bus.o_busy       = (state_q == S_RUN) || (state_q == S_DONE);
    // An abort arriving in the DONE cycle suppresses the completion report.
    assign bus.o_done       = (state_q == S_DONE) && !bus.i_abort;
    assign bus.o_isc_err    = isc_err_q;
    assign bus.o_Isc        = isc_q;
    assign bus.o_sym_idx    = sym_idx_q;
    assign bus.o_slot_idx   = slot_idx_q;
    assign bus.o_DMRS_valid = (state_q == S_RUN) && bus.i_FFT_Valid && w_is_dmrs;
    assign bus.o_data_valid = (state_q == S_RUN) && bus.i_FFT_Valid && !w_is_dmrs;

endmodule

`default_nettype wire

// File: tb/tb_npusch_demap_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_npusch_demap_ctrl                                         |
// | Description : Directed scoreboard bench for the NPUSCH demapper sequencer. |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_npusch_demap_ctrl;

    logic clk;
    logic rst_n;

    npusch_demap_ctrl_if bus ();

    npusch_demap_ctrl #(
        .SYMS_PER_SLOT (7),
        .DMRS_SYM      (3)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    bit         m_run;
    bit         m_done_pend;
    bit         m_err_pend;
    logic [2:0] m_sym;
    logic [7:0] m_slot;
    logic [7:0] m_last;
    logic [5:0] m_isc;
    logic [12:0] sb_q[$];
    int         nru_tab[8] = '{1, 2, 3, 4, 5, 6, 8, 10};

    int n_done_seen;
    int n_dmrs_seen;
    int n_data_seen;
    int max_slot_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        n_done_seen   = 0;
        n_dmrs_seen   = 0;
        n_data_seen   = 0;
        max_slot_seen = 0;
    endtask

    // One clock cycle: drive at negedge, check 1 time unit later, update model.
    task automatic cyc(input bit v, input bit ab, input bit st,
                       input logic [5:0] isc, input logic [2:0] nru);
        bit          exp_done_st;
        bit          idle_now;
        logic [12:0] e;
        int          spr;
        @(negedge clk);
        bus.i_FFT_Valid = v;
        bus.i_abort     = ab;
        bus.i_start     = st;
        bus.i_Isc       = isc;
        bus.i_N_RU      = nru;
        exp_done_st = m_done_pend;
        idle_now    = !m_run && !m_done_pend;
        if (v && m_run)
            sb_q.push_back({(m_sym == 3'd3), (m_sym != 3'd3), m_sym, m_slot});
        #1;
        chk("en",      {31'd0, bus.o_en},      {31'd0, m_run});
        chk("busy",    {31'd0, bus.o_busy},    {31'd0, (m_run | exp_done_st)});
        chk("done",    {31'd0, bus.o_done},    {31'd0, (exp_done_st & ~ab)});
        chk("isc_err", {31'd0, bus.o_isc_err}, {31'd0, m_err_pend});
        chk("o_isc",   {26'd0, bus.o_Isc},     {26'd0, m_isc});
        if (v && m_run) begin
            e = sb_q.pop_front();
            chk("dmrs_valid", {31'd0, bus.o_DMRS_valid}, {31'd0, e[12]});
            chk("data_valid", {31'd0, bus.o_data_valid}, {31'd0, e[11]});
            chk("sym_idx",    {29'd0, bus.o_sym_idx},    {29'd0, e[10:8]});
            chk("slot_idx",   {24'd0, bus.o_slot_idx},   {24'd0, e[7:0]});
        end else if (!m_run) begin
            chk("dmrs_idle", {31'd0, bus.o_DMRS_valid}, 32'd0);
            chk("data_idle", {31'd0, bus.o_data_valid}, 32'd0);
        end
        if (idle_now) begin
            chk("sym_idle",  {29'd0, bus.o_sym_idx},  32'd0);
            chk("slot_idle", {24'd0, bus.o_slot_idx}, 32'd0);
        end
        if (bus.o_done)       n_done_seen++;
        if (bus.o_DMRS_valid) n_dmrs_seen++;
        if (bus.o_data_valid) n_data_seen++;
        if (bus.o_en && int'(bus.o_slot_idx) > max_slot_seen) max_slot_seen = int'(bus.o_slot_idx);

        m_err_pend  = 1'b0;
        m_done_pend = 1'b0;
        if (m_run) begin
            if (ab) begin
                m_run = 1'b0; m_sym = '0; m_slot = '0;
            end else if (v) begin
                if (m_sym == 3'd6) begin
                    m_sym = '0;
                    if (m_slot == m_last) begin
                        m_run = 1'b0; m_slot = '0; m_done_pend = 1'b1;
                    end else begin
                        m_slot = m_slot + 8'd1;
                    end
                end else begin
                    m_sym = m_sym + 3'd1;
                end
            end
        end else if (idle_now && st && !ab) begin
            if (isc <= 6'd18) begin
                if (isc <= 6'd11)      spr = 16;
                else if (isc <= 6'd15) spr = 8;
                else if (isc <= 6'd17) spr = 4;
                else                   spr = 2;
                m_run  = 1'b1;
                m_isc  = isc;
                m_sym  = '0;
                m_slot = '0;
                m_last = 8'(nru_tab[nru] * spr - 1);
            end else begin
                m_err_pend = 1'b1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 6'd0, 3'd0);
    endtask

    task automatic valids(input int n, input int gap_max);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, gap_max)) cyc(1'b0, 1'b0, 1'b0, 6'd0, 3'd0);
            cyc(1'b1, 1'b0, 1'b0, 6'd0, 3'd0);
        end
    endtask

    task automatic model_reset();
        m_run = 1'b0; m_done_pend = 1'b0; m_err_pend = 1'b0;
        m_sym = '0; m_slot = '0; m_last = '0; m_isc = '0;
        sb_q.delete();
    endtask

    initial begin
        model_reset();
        clear_stats();
        rst_n           = 1'b0;
        bus.i_start     = 1'b0;
        bus.i_abort     = 1'b0;
        bus.i_Isc       = 6'd0;
        bus.i_N_RU      = 3'd0;
        bus.i_FFT_Valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_en",    {31'd0, bus.o_en},      32'd0);
        chk("rst_busy",  {31'd0, bus.o_busy},    32'd0);
        chk("rst_done",  {31'd0, bus.o_done},    32'd0);
        chk("rst_err",   {31'd0, bus.o_isc_err}, 32'd0);
        chk("rst_isc",   {26'd0, bus.o_Isc},     32'd0);
        chk("rst_sym",   {29'd0, bus.o_sym_idx}, 32'd0);
        chk("rst_slot",  {24'd0, bus.o_slot_idx}, 32'd0);
        rst_n = 1'b1;
        idle(2);

        // 1 RU of 2 slots, back-to-back symbols
        clear_stats();
        cyc(1'b0, 1'b0, 1'b1, 6'd18, 3'd0);
        valids(14, 0);
        idle(3);
        chk("a_dmrs_cnt", n_dmrs_seen, 2);
        chk("a_data_cnt", n_data_seen, 12);
        chk("a_done_cnt", n_done_seen, 1);

        // Illegal Isc, then abort+start in IDLE
        cyc(1'b0, 1'b0, 1'b1, 6'd20, 3'd3);
        idle(2);
        cyc(1'b0, 1'b1, 1'b1, 6'd5, 3'd0);
        idle(2);

        // 80 slots with random gaps, then strobes after completion
        clear_stats();
        cyc(1'b0, 1'b0, 1'b1, 6'd12, 3'd7);
        valids(560, 2);
        valids(5, 1);
        idle(2);
        chk("b_max_slot", max_slot_seen, 79);
        chk("b_done_cnt", n_done_seen, 1);

        // 160 slots
        clear_stats();
        cyc(1'b0, 1'b0, 1'b1, 6'd5, 3'd7);
        valids(1120, 0);
        idle(3);
        chk("c_max_slot", max_slot_seen, 159);
        chk("c_done_cnt", n_done_seen, 1);

        // 8 slots, ignored restart, abort at slot 2 symbol 4
        clear_stats();
        cyc(1'b0, 1'b0, 1'b1, 6'd16, 3'd1);
        valids(10, 0);
        cyc(1'b1, 1'b0, 1'b1, 6'd0, 3'd0);
        valids(7, 0);
        cyc(1'b1, 1'b1, 1'b0, 6'd0, 3'd0);
        idle(3);
        chk("d_done_cnt", n_done_seen, 0);
        chk("d_max_slot", max_slot_seen, 2);

        // Asynchronous reset mid-slot, then a fresh full allocation
        cyc(1'b0, 1'b0, 1'b1, 6'd0, 3'd0);
        valids(10, 0);
        @(negedge clk);
        bus.i_FFT_Valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_en",   {31'd0, bus.o_en},         32'd0);
        chk("ar_busy", {31'd0, bus.o_busy},       32'd0);
        chk("ar_done", {31'd0, bus.o_done},       32'd0);
        chk("ar_isc",  {26'd0, bus.o_Isc},        32'd0);
        chk("ar_sym",  {29'd0, bus.o_sym_idx},    32'd0);
        chk("ar_slot", {24'd0, bus.o_slot_idx},   32'd0);
        chk("ar_dmrs", {31'd0, bus.o_DMRS_valid}, 32'd0);
        chk("ar_data", {31'd0, bus.o_data_valid}, 32'd0);
        bus.i_FFT_Valid = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        clear_stats();
        cyc(1'b0, 1'b0, 1'b1, 6'd17, 3'd2);
        valids(84, 1);
        idle(3);
        chk("e_max_slot", max_slot_seen, 11);
        chk("e_done_cnt", n_done_seen, 1);
        chk("e_sb_empty", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
